// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package : alu_pkg
// Brief   : Opcodes, FSM state encoding and opcode helpers for alu_seq.
// Rev     : 1.0  initial release
// ============================================================================
package alu_pkg;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } alu_state_t;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_SRL);
    endfunction

    function automatic logic is_iter(input logic [2:0] op);
        return is_shift(op) || (op == OP_MUL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Interface : alu_seq_if
// Brief     : Request/response bundle between the control unit and alu_seq.
// Rev       : 1.0  initial release
// ============================================================================
interface alu_seq_if #(
    parameter int WIDTH = 8
) ();

    logic             start;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [2:0]       select;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             busy;
    logic             done;

    modport master (
        output start, data1, data2, select,
        input  result, zero, carry, busy, done
    );

    modport slave (
        input  start, data1, data2, select,
        output result, zero, carry, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/alu_seq_iter_unit.sv
`default_nettype none
// ============================================================================
// Module : alu_iter_unit
// Brief  : Bit-serial shift / shift-add multiply datapath with its step counter.
// Rev    : 1.0  initial release
// ============================================================================
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             load,
    input  wire logic             step,
    input  wire logic [2:0]       op,
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    output logic      [WIDTH-1:0] acc,
    output logic                  last
);

    localparam int SHW = $clog2(WIDTH);

    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] w_acc_step;

    always_comb begin
        w_acc_step = r_acc;
        case (r_op)
            OP_SLL:  w_acc_step = r_acc << 1;
            OP_SRL:  w_acc_step = r_acc >> 1;
            OP_MUL:  w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);
            default: w_acc_step = r_acc;
        endcase
    end

    // acc is the value the accumulator takes at this step, so the top can
    // capture the final answer on the same edge as the last step.
    assign acc  = w_acc_step;
    assign last = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= OP_FWD;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (load) begin
            r_op     <= op;
            r_acc    <= (op == OP_MUL) ? '0 : a;
            r_mcand  <= a;
            r_mplier <= b;
            r_cnt    <= (op == OP_MUL) ? SHW'(WIDTH - 1) : (b[SHW-1:0] - SHW'(1));
        end else if (step) begin
            r_acc    <= w_acc_step;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - SHW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module : alu_seq
// Brief  : Clocked ALU: single-cycle logic/arith ops plus iterative shift/mul.
// Rev    : 1.0  initial release
// ============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic clk,
    input  wire logic reset,
    alu_seq_if.slave  bus
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_t       r_state;
    alu_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_carry;

    logic             w_accept;
    logic             w_launch;
    logic             w_single;
    logic             w_step;
    logic             w_busy;
    logic             w_done;
    logic             w_last;
    logic [WIDTH-1:0] w_acc;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_sres;
    logic             w_scarry;

    // A zero-length shift has nothing to iterate, so it finishes like a single-cycle op.
    assign w_accept = bus.start && ((r_state == IDLE) || (r_state == FIN));
    assign w_launch = w_accept && is_iter(bus.select)
                      && !(is_shift(bus.select) && (bus.data2[SHW-1:0] == '0));
    assign w_single = w_accept && !w_launch;

    assign w_sum  = {1'b0, bus.data1} + {1'b0, bus.data2};
    assign w_diff = {1'b0, bus.data1} - {1'b0, bus.data2};

    always_comb begin
        w_sres   = '0;
        w_scarry = 1'b0;
        case (bus.select)
            OP_FWD: w_sres = bus.data2;
            OP_ADD: begin
                w_sres   = w_sum[WIDTH-1:0];
                w_scarry = w_sum[WIDTH];
            end
            OP_AND: w_sres = bus.data1 & bus.data2;
            OP_OR:  w_sres = bus.data1 | bus.data2;
            OP_SUB: begin
                w_sres   = w_diff[WIDTH-1:0];
                w_scarry = w_diff[WIDTH];
            end
            OP_SLL, OP_SRL: w_sres = bus.data1;
            default: w_sres = '0;
        endcase
    end

    alu_iter_unit #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk   (clk),
        .reset (reset),
        .load  (w_launch),
        .step  (w_step),
        .op    (bus.select),
        .a     (bus.data1),
        .b     (bus.data2),
        .acc   (w_acc),
        .last  (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, FIN: begin
                if (w_launch) begin
                    w_state_nxt = RUN;
                end else if (w_single) begin
                    w_state_nxt = FIN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN:     w_state_nxt = w_last ? FIN : RUN;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_step = 1'b0;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            RUN: begin
                w_step = 1'b1;
                w_busy = 1'b1;
            end
            FIN:     w_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_zero   <= 1'b1;
            r_carry  <= 1'b0;
        end else if (w_single) begin
            r_result <= w_sres;
            r_zero   <= (w_sres == '0);
            r_carry  <= w_scarry;
        end else if (w_step && w_last) begin
            r_result <= w_acc;
            r_zero   <= (w_acc == '0);
            r_carry  <= 1'b0;
        end
    end

    assign bus.result = r_result;
    assign bus.zero   = r_zero;
    assign bus.carry  = r_carry;
    assign bus.busy   = w_busy;
    assign bus.done   = w_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_seq
// Brief  : Directed scoreboard bench for alu_seq (WIDTH = 8).
// Rev    : 1.0  initial release
// ============================================================================
module tb_alu_seq;
    import alu_pkg::*;

    typedef struct {
        int         cyc;
        logic [7:0] res;
        logic       z;
        logic       c;
    } exp_t;

    typedef struct {
        int         cyc;
        bit         full;
        logic       busy;
        logic       done;
        logic [7:0] res;
        logic       z;
        logic       c;
    } probe_t;

    logic   clk = 1'b0;
    logic   reset = 1'b1;
    int     cyc = 0;
    int     total = 0;
    int     bad = 0;
    exp_t   sb[$];
    probe_t pq[$];
    exp_t   e_m;
    probe_t p_m;

    alu_seq_if #(.WIDTH(8)) bus ();

    alu_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every DONE and services state probes.
    always @(negedge clk) begin
        if (!reset) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e_m = sb.pop_front();
                chk("missed_done", 32'(0), 32'(1));
            end
            if (bus.done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'(1), 32'(0));
                end else begin
                    e_m = sb.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e_m.cyc));
                    chk("result", 32'(bus.result), 32'(e_m.res));
                    chk("zero", 32'(bus.zero), 32'(e_m.z));
                    chk("carry", 32'(bus.carry), 32'(e_m.c));
                end
            end
        end
        while (pq.size() > 0 && pq[0].cyc < cyc) begin
            p_m = pq.pop_front();
            chk("probe_missed", 32'(0), 32'(1));
        end
        while (pq.size() > 0 && pq[0].cyc == cyc) begin
            p_m = pq.pop_front();
            chk("busy", 32'(bus.busy), 32'(p_m.busy));
            chk("done", 32'(bus.done), 32'(p_m.done));
            if (p_m.full) begin
                chk("state_result", 32'(bus.result), 32'(p_m.res));
                chk("state_zero", 32'(bus.zero), 32'(p_m.z));
                chk("state_carry", 32'(bus.carry), 32'(p_m.c));
            end
        end
    end

    task automatic probe(input int at, input bit full, input logic busy, input logic done,
                         input logic [7:0] res, input logic z, input logic c);
        probe_t p;
        p.cyc = at; p.full = full; p.busy = busy; p.done = done;
        p.res = res; p.z = z; p.c = c;
        pq.push_back(p);
    endtask

    task automatic start_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.select = op;
        bus.data1  = a;
        bus.data2  = b;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
    endtask

    // Expected DONE lands at (current cycle + latency) as seen by the monitor.
    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input int lat, input logic [7:0] res, input logic z, input logic c);
        exp_t e;
        e.cyc = cyc + lat; e.res = res; e.z = z; e.c = c;
        sb.push_back(e);
        start_op(op, a, b);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (!bus.busy && !bus.done && sb.size() == 0) break;
        end
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.data1  = '0;
        bus.data2  = '0;
        bus.select = OP_FWD;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        probe(cyc, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        @(posedge clk);
        #1;

        issue(OP_ADD, 8'hFF, 8'h01, 1, 8'h00, 1'b1, 1'b1);
        probe(cyc, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        wait_idle();

        issue(OP_SUB, 8'h03, 8'h05, 1, 8'hFE, 1'b0, 1'b1);
        wait_idle();

        issue(OP_FWD, 8'h00, 8'hA5, 1, 8'hA5, 1'b0, 1'b0);
        issue(OP_OR,  8'h0F, 8'hF0, 1, 8'hFF, 1'b0, 1'b0);
        wait_idle();

        issue(OP_AND, 8'h0F, 8'hF0, 1, 8'h00, 1'b1, 1'b0);
        wait_idle();

        issue(OP_SLL, 8'h81, 8'h03, 4, 8'h08, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) probe(cyc + k, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        probe(cyc + 3, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        wait_idle();

        issue(OP_SLL, 8'h81, 8'h00, 1, 8'h81, 1'b0, 1'b0);
        wait_idle();

        issue(OP_SRL, 8'h80, 8'h07, 8, 8'h01, 1'b0, 1'b0);
        wait_idle();

        issue(OP_MUL, 8'd13, 8'd11, 9, 8'h8F, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        start_op(OP_ADD, 8'hFF, 8'h01);
        bus.data1 = 8'h55;
        wait_idle();

        issue(OP_MUL, 8'hFF, 8'hFF, 9, 8'h01, 1'b0, 1'b0);
        wait_idle();
        issue(OP_MUL, 8'd16, 8'd16, 9, 8'h00, 1'b1, 1'b0);
        wait_idle();

        // Abort a MUL in its fourth cycle after leaving non-reset outputs behind.
        issue(OP_ADD, 8'hFF, 8'hFF, 1, 8'hFE, 1'b0, 1'b1);
        wait_idle();
        start_op(OP_MUL, 8'd7, 8'd9);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        probe(cyc, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        repeat (12) begin
            @(posedge clk);
            #1;
        end

        // Reset and start in the same cycle: start must be dropped.
        issue(OP_ADD, 8'hFF, 8'hFF, 1, 8'hFE, 1'b0, 1'b1);
        wait_idle();
        reset      = 1'b1;
        bus.select = OP_AND;
        bus.data1  = 8'hFF;
        bus.data2  = 8'hFF;
        bus.start  = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        bus.start = 1'b0;
        probe(cyc, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        probe(cyc + 1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        repeat (20) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
